logic_pipe: RTL

LOGIC_PIPE -- requirements
Module: logic_pipe

---
 rtl/logic_pipe_pkg.sv | 30 +++
 rtl/logic_pipe_stage.sv | 32 +++
 rtl/logic_pipe.sv | 79 +++++++
 3 files changed

// File: rtl/logic_pipe_pkg.sv
// Shared types and helpers for the logic_pipe bitwise pipeline.
package logic_pipe_pkg;

  localparam int unsigned COUNT_W = 16;
  localparam int unsigned MAX_W   = 64;

  typedef enum logic [1:0] {
    OP_AND  = 2'd0,
    OP_OR   = 2'd1,
    OP_XOR  = 2'd2,
    OP_NAND = 2'd3
  } logic_op_t;

  // Bitwise evaluation at maximum width; callers truncate to their own width.
  function automatic logic [MAX_W-1:0] logic_eval(input logic [MAX_W-1:0] a,
                                                  input logic [MAX_W-1:0] b,
                                                  input logic_op_t        op);
    logic [MAX_W-1:0] r;
    r = '0;
    case (op)
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_NAND: r = ~(a & b);
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/logic_pipe_stage.sv
// One elastic pipeline slot: data register plus valid bit, ready chained from downstream.
module logic_pipe_stage
  import logic_pipe_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         up_valid,
  input  logic [W-1:0] up_data,
  output logic         up_ready_c,
  output logic         dn_valid,
  output logic [W-1:0] dn_data,
  input  logic         dn_ready
);

  // Slot may load when empty or when its content leaves this cycle.
  assign up_ready_c = !dn_valid || dn_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dn_valid <= 1'b0;
      dn_data  <= '0;
    end else if (up_ready_c) begin
      dn_valid <= up_valid;
      if (up_valid) begin
        dn_data <= up_data;
      end
    end
  end

endmodule

// File: rtl/logic_pipe.sv
// Bitwise AND/OR/XOR/NAND pipeline of DEPTH elastic stages with output accept counter.
// Optional feature macro LOGIC_PIPE_PARITY_EN adds a registered even-parity output y_par.
module logic_pipe
  import logic_pipe_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [1:0]         op,
  output logic [WIDTH-1:0]   y,
  output logic               y_valid,
  input  logic               y_ready,
  output logic [COUNT_W-1:0] count
`ifdef LOGIC_PIPE_PARITY_EN
  ,
  output logic               y_par
`endif
);

`ifdef LOGIC_PIPE_PARITY_EN
  localparam int unsigned PAR_W = 1;
`else
  localparam int unsigned PAR_W = 0;
`endif
  localparam int unsigned SW = WIDTH + PAR_W;

  logic [WIDTH-1:0] res;
  logic [SW-1:0]    s_data  [DEPTH+1];
  logic             s_valid [DEPTH+1];
  logic             s_ready [DEPTH+1];

  assign res = WIDTH'(logic_eval(MAX_W'(a), MAX_W'(b), logic_op_t'(op)));

`ifdef LOGIC_PIPE_PARITY_EN
  assign s_data[0] = {^res, res};
`else
  assign s_data[0] = res;
`endif
  assign s_valid[0]     = in_valid;
  assign s_ready[DEPTH] = y_ready;
  assign in_ready       = s_ready[0];

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    logic_pipe_stage #(
      .W (SW)
    ) u_stage (
      .clk        (clk),
      .rst        (rst),
      .up_valid   (s_valid[k]),
      .up_data    (s_data[k]),
      .up_ready_c (s_ready[k]),
      .dn_valid   (s_valid[k+1]),
      .dn_data    (s_data[k+1]),
      .dn_ready   (s_ready[k+1])
    );
  end

  assign y       = s_data[DEPTH][WIDTH-1:0];
  assign y_valid = s_valid[DEPTH];
`ifdef LOGIC_PIPE_PARITY_EN
  assign y_par   = s_data[DEPTH][WIDTH];
`endif

  // Results handed to the consumer; wraps naturally at the counter width.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (y_valid && y_ready) begin
      count <= count + COUNT_W'(1);
    end
  end

endmodule
